// File: rtl/mon_nchan_bb.sv
// N-channel baseband monitor: per-channel second-order integrators snapshotted
// on samp into a daisy-chainable serial shift chain, with a sticky overrun flag.
module mon_nchan_bb #(
  parameter int NCH  = 2,
  parameter int DWI  = 16,
  parameter int RWI  = 28,
  parameter int DAVR = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*DWI-1:0] din,
  input  logic               samp,
  input  logic               clr,
  input  logic [RWI-1:0]     s_in,
  input  logic               g_in,
  output logic [RWI-1:0]     s_out,
  output logic               g_out,
  output logic               overrun
);

  localparam int             CW       = $clog2(NCH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(NCH);

  logic [RWI-1:0] i1_q    [NCH];
  logic [RWI-1:0] i1_d    [NCH];
  logic [RWI-1:0] i2_q    [NCH];
  logic [RWI-1:0] i2_d    [NCH];
  logic [RWI-1:0] chain_q [NCH];
  logic [RWI-1:0] chain_d [NCH];
  logic [NCH-1:0] gate_q, gate_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovr_q, ovr_d;

  // Scale by 2^DAVR, then sign-extend into the accumulator width.
  function automatic logic [RWI-1:0] widen(input logic [DWI-1:0] s);
    logic signed [DWI+DAVR-1:0] t;
    t = {s, {DAVR{1'b0}}};
    return RWI'(t);
  endfunction

  always_comb begin : integ_next
    for (int k = 0; k < NCH; k++) begin
      if (clr) begin
        i1_d[k] = '0;
        i2_d[k] = '0;
      end else begin
        i1_d[k] = i1_q[k] + widen(din[k*DWI +: DWI]);
        i2_d[k] = i2_q[k] + i1_q[k];
      end
    end
  end

  always_comb begin : chain_next
    // NOTE: every combinational output gets a default first so no path infers a latch.
    chain_d = chain_q;
    gate_d  = gate_q;
    if (samp) begin
      // Snapshot uses the registered i2, so a coincident clr still yields pre-clear data.
      for (int k = 0; k < NCH; k++) chain_d[k] = i2_q[k];
      gate_d = '1;
    end else begin
      for (int k = 0; k < NCH - 1; k++) begin
        chain_d[k] = chain_q[k+1];
        gate_d[k]  = gate_q[k+1];
      end
      chain_d[NCH-1] = s_in;
      gate_d[NCH-1]  = g_in;
    end
  end

  always_comb begin : ovr_next
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (samp) begin
      cnt_d = CW'(1);
      if (cnt_q < CNT_FULL) ovr_d = 1'b1;
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these arrays are datapath registers, not RAM, so they are reset explicitly.
      for (int k = 0; k < NCH; k++) begin
        i1_q[k]    <= '0;
        i2_q[k]    <= '0;
        chain_q[k] <= '0;
      end
      gate_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      chain_q <= chain_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign s_out   = chain_q[0];
  assign g_out   = gate_q[0];
  assign overrun = ovr_q;

endmodule
